// File: rtl/ctrlport_reg_responder_pkg.sv
// Shared ctrlport definitions: bus widths, response status codes and the
// responder FSM encoding.
package ctrlport_reg_responder_pkg;

  localparam int CTRLPORT_ADDR_W = 20;
  localparam int CTRLPORT_DATA_W = 32;
  localparam int CTRLPORT_BE_W   = CTRLPORT_DATA_W / 8;

  typedef enum logic [1:0] {
    STS_OKAY    = 2'd0,
    STS_CMDERR  = 2'd1,
    STS_TSERR   = 2'd2,
    STS_WARNING = 2'd3
  } ctrlport_status_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } resp_state_t;

  // Expand per-byte enables into a per-bit write mask.
  function automatic logic [CTRLPORT_DATA_W-1:0] be_to_mask(input logic [CTRLPORT_BE_W-1:0] be);
    logic [CTRLPORT_DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < CTRLPORT_BE_W; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/ctrlport_reg_responder.sv
// Ctrlport slave exposing NUM_REGS byte-writable registers with a fixed
// request-to-ack latency; one request in flight, extras are dropped and flagged.
module ctrlport_reg_responder
  import ctrlport_reg_responder_pkg::*;
#(
  parameter int          BASE_ADDR   = 0,
  parameter int          NUM_REGS    = 4,
  parameter int          REG_W       = 16,
  parameter logic [31:0] RESET_VAL   = 32'd1,
  parameter int          ACK_LATENCY = 1
) (
  input  logic                       ctrlport_clk,
  input  logic                       ctrlport_rst,
  input  logic                       s_ctrlport_req_wr,
  input  logic                       s_ctrlport_req_rd,
  input  logic [CTRLPORT_ADDR_W-1:0] s_ctrlport_req_addr,
  input  logic [CTRLPORT_DATA_W-1:0] s_ctrlport_req_data,
  input  logic [CTRLPORT_BE_W-1:0]   s_ctrlport_req_byte_en,
  output logic                       s_ctrlport_resp_ack,
  output logic [1:0]                 s_ctrlport_resp_status,
  output logic [CTRLPORT_DATA_W-1:0] s_ctrlport_resp_data,
  output logic [NUM_REGS*REG_W-1:0]  regs,
  output logic [NUM_REGS-1:0]        reg_wr_stb,
  output logic                       dropped_req
);

  localparam int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);
  localparam logic [31:0] LIMIT     = 32'(BASE_ADDR + 4*NUM_REGS);
  localparam logic [3:0]  WAIT_LOAD = 4'(ACK_LATENCY - 2);
  localparam resp_state_t ST_ACCEPT = (ACK_LATENCY == 1) ? ST_ACK : ST_WAIT;

  resp_state_t state, state_nxt;
  logic [3:0]  cnt;

  logic                       req, accept, req_hit;
  logic [31:0]                req_addr32, req_offs;
  logic                       cap_wr, cap_rd, cap_err;
  logic [IDX_W-1:0]           cap_idx;
  logic [CTRLPORT_DATA_W-1:0] cap_data;
  logic [CTRLPORT_BE_W-1:0]   cap_be;

  logic [NUM_REGS-1:0][REG_W-1:0] reg_q;
  logic [CTRLPORT_DATA_W-1:0]     cur_word, merged, wmask;
  logic                           ack_cyc, wr_fire;

  assign req        = s_ctrlport_req_wr | s_ctrlport_req_rd;
  // The ACK cycle doubles as an accept slot so back-to-back traffic loses no cycle.
  assign accept     = req && (state == ST_IDLE || state == ST_ACK);
  assign req_addr32 = 32'(s_ctrlport_req_addr);
  assign req_offs   = req_addr32 - BASE;
  assign req_hit    = (req_addr32 >= BASE) && (req_addr32 < LIMIT) &&
                      (s_ctrlport_req_addr[1:0] == 2'b00);

  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cap_wr      <= 1'b0;
      cap_rd      <= 1'b0;
      cap_err     <= 1'b0;
      cap_idx     <= '0;
      cap_data    <= '0;
      cap_be      <= '0;
      dropped_req <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= WAIT_LOAD;
        cap_wr   <= s_ctrlport_req_wr & ~s_ctrlport_req_rd & req_hit;
        cap_rd   <= s_ctrlport_req_rd & ~s_ctrlport_req_wr & req_hit;
        cap_err  <= (s_ctrlport_req_wr & s_ctrlport_req_rd) | ~req_hit;
        cap_idx  <= IDX_W'(req_offs >> 2);
        cap_data <= s_ctrlport_req_data;
        cap_be   <= s_ctrlport_req_byte_en;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (req && state == ST_WAIT) dropped_req <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = ST_ACCEPT;
      ST_WAIT: if (cnt == '0) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = req ? ST_ACCEPT : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_cyc  = (state == ST_ACK);
    wr_fire  = ack_cyc && cap_wr && (cap_be != '0);
    cur_word = '0;
    cur_word[REG_W-1:0] = reg_q[cap_idx];
    wmask    = be_to_mask(cap_be);
    merged   = (cur_word & ~wmask) | (cap_data & wmask);

    s_ctrlport_resp_ack    = ack_cyc;
    s_ctrlport_resp_status = (ack_cyc && cap_err) ? STS_CMDERR : STS_OKAY;
    s_ctrlport_resp_data   = (ack_cyc && cap_rd) ? cur_word : '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_wr_stb[i] = wr_fire && (cap_idx == IDX_W'(i));
  end

  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      reg_q <= {NUM_REGS{RESET_VAL[REG_W-1:0]}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (reg_wr_stb[i]) reg_q[i] <= REG_W'(merged);
    end
  end

  assign regs = reg_q;

endmodule

// File: tb/tb_ctrlport_reg_responder.sv
// Randomized self-checking bench for ctrlport_reg_responder against a
// behavioural register-file model.
module tb_ctrlport_reg_responder;

  localparam int          BASE = 32'h100;
  localparam int          N    = 4;
  localparam int          RW   = 16;
  localparam logic [31:0] RV   = 32'h0000_0001;
  localparam int          LAT  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_wr, req_rd;
  logic [19:0]   req_addr;
  logic [31:0]   req_data;
  logic [3:0]    req_be;
  logic          resp_ack;
  logic [1:0]    resp_status;
  logic [31:0]   resp_data;
  logic [N*RW-1:0] regs;
  logic [N-1:0]  stb;
  logic          dropped;

  // second instance: single-cycle latency, 2 x 8-bit registers at address 0
  logic          b_wr, b_rd;
  logic [19:0]   b_addr;
  logic [31:0]   b_data;
  logic [3:0]    b_be;
  logic          b_ack;
  logic [1:0]    b_status;
  logic [31:0]   b_rdata;
  logic [15:0]   b_regs;
  logic [1:0]    b_stb;
  logic          b_dropped;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] m_regs [N];

  always #5 clk = ~clk;

  ctrlport_reg_responder #(
    .BASE_ADDR(BASE), .NUM_REGS(N), .REG_W(RW), .RESET_VAL(RV), .ACK_LATENCY(LAT)
  ) dut (
    .ctrlport_clk(clk), .ctrlport_rst(rst),
    .s_ctrlport_req_wr(req_wr), .s_ctrlport_req_rd(req_rd),
    .s_ctrlport_req_addr(req_addr), .s_ctrlport_req_data(req_data),
    .s_ctrlport_req_byte_en(req_be),
    .s_ctrlport_resp_ack(resp_ack), .s_ctrlport_resp_status(resp_status),
    .s_ctrlport_resp_data(resp_data),
    .regs(regs), .reg_wr_stb(stb), .dropped_req(dropped)
  );

  ctrlport_reg_responder #(
    .BASE_ADDR(0), .NUM_REGS(2), .REG_W(8), .RESET_VAL(32'h1234_5678), .ACK_LATENCY(1)
  ) dut1 (
    .ctrlport_clk(clk), .ctrlport_rst(rst),
    .s_ctrlport_req_wr(b_wr), .s_ctrlport_req_rd(b_rd),
    .s_ctrlport_req_addr(b_addr), .s_ctrlport_req_data(b_data),
    .s_ctrlport_req_byte_en(b_be),
    .s_ctrlport_resp_ack(b_ack), .s_ctrlport_resp_status(b_status),
    .s_ctrlport_resp_data(b_rdata),
    .regs(b_regs), .reg_wr_stb(b_stb), .dropped_req(b_dropped)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = RV[RW-1:0];
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic [19:0] a,
                            input logic [31:0] d, input logic [3:0] be,
                            output logic [1:0] es, output logic [31:0] ed,
                            output logic [N-1:0] estb);
    bit inr;
    int idx;
    logic [31:0] w;
    inr  = (int'(a) >= BASE) && (int'(a) < BASE + 4*N) && (int'(a) % 4 == 0);
    idx  = inr ? (int'(a) - BASE) / 4 : 0;
    es   = ((wr && rd) || !inr) ? 2'd1 : 2'd0;
    ed   = '0;
    estb = '0;
    if (es == 2'd0 && rd) ed = 32'(m_regs[idx]);
    if (es == 2'd0 && wr && be != 4'h0) begin
      w = 32'(m_regs[idx]);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      m_regs[idx] = w[RW-1:0];
      estb[idx] = 1'b1;
    end
  endtask

  function automatic logic [N*RW-1:0] m_flat();
    logic [N*RW-1:0] r;
    for (int i = 0; i < N; i++) r[i*RW +: RW] = m_regs[i];
    return r;
  endfunction

  // ---------------- driver (observes only, no checks) ----------------
  // lat counts cycles after the request cycle until ack; -1 on timeout.
  // bad counts cycles with nonzero status/data while ack is low, or extra acks.
  task automatic run_req(input logic wr, input logic rd, input logic [19:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output int lat, output logic [1:0] sts, output logic [31:0] dat,
                         output logic [N-1:0] stb_seen, output int stb_cyc, output int bad);
    lat = -1; sts = '0; dat = '0; stb_seen = '0; stb_cyc = 0; bad = 0;
    @(negedge clk);
    req_wr = wr; req_rd = rd; req_addr = a; req_data = d; req_be = be;
    @(posedge clk); #1;
    req_wr = 1'b0; req_rd = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (stb != '0) begin stb_cyc++; stb_seen |= stb; end
      if (resp_ack) begin lat = n; sts = resp_status; dat = resp_data; end
      else if (resp_status != 2'd0 || resp_data != 32'd0) bad++;
    end
    @(posedge clk); #1;
    if (stb != '0) stb_cyc++;
    if (resp_ack || resp_status != 2'd0 || resp_data != 32'd0) bad++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat, sc, bad; logic [1:0] s; logic [31:0] d; logic [N-1:0] ss;
    rst = 1'b1;
    req_wr = 0; req_rd = 0; req_addr = '0; req_data = '0; req_be = '0;
    b_wr = 0; b_rd = 0; b_addr = '0; b_data = '0; b_be = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (resp_ack !== 1'b0 || resp_status !== 2'd0 || resp_data !== 32'd0 || stb !== '0 || dropped !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b sts=%0d data=%h stb=%b dropped=%b, required all 0",
               resp_ack, resp_status, resp_data, stb, dropped);
    end
    checks++;
    if (regs !== m_flat()) begin
      failures++; $display("FAIL reset_regs: got %h required %h", regs, m_flat());
    end
    rst = 1'b0;
    run_req(1'b0, 1'b1, 20'(BASE), 32'h0, 4'h0, lat, s, d, ss, sc, bad);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL reset_read_latency: got %0d required %0d", lat, LAT); end
    checks++;
    if (s !== 2'd0 || d !== 32'h0000_0001) begin
      failures++; $display("FAIL reset_read_value: got sts=%0d data=%h required sts=0 data=00000001", s, d);
    end
  endtask

  task automatic test_full_write();
    int lat, sc, bad; logic [1:0] s, es; logic [31:0] d, ed; logic [N-1:0] ss, estb;
    model_step(1'b1, 1'b0, 20'(BASE), 32'h1234_8765, 4'hF, es, ed, estb);
    run_req(1'b1, 1'b0, 20'(BASE), 32'h1234_8765, 4'hF, lat, s, d, ss, sc, bad);
    checks++;
    if (lat !== LAT || s !== es || d !== ed || bad !== 0) begin
      failures++; $display("FAIL full_write_resp: lat=%0d sts=%0d data=%h bad=%0d required lat=%0d sts=%0d data=%h bad=0",
                           lat, s, d, bad, LAT, es, ed);
    end
    checks++;
    if (ss !== 4'b0001 || sc !== 1) begin
      failures++; $display("FAIL full_write_stb: mask=%b cycles=%0d required mask=0001 cycles=1", ss, sc);
    end
    checks++;
    if (regs !== m_flat()) begin failures++; $display("FAIL full_write_regs: got %h required %h", regs, m_flat()); end
    model_step(1'b0, 1'b1, 20'(BASE), 32'h0, 4'h0, es, ed, estb);
    run_req(1'b0, 1'b1, 20'(BASE), 32'h0, 4'h0, lat, s, d, ss, sc, bad);
    checks++;
    if (s !== 2'd0 || d !== 32'h0000_8765 || d !== ed) begin
      failures++; $display("FAIL full_write_readback: got sts=%0d data=%h required sts=0 data=00008765", s, d);
    end
  endtask

  task automatic test_byte_en();
    int lat, sc, bad; logic [1:0] s, es; logic [31:0] d, ed; logic [N-1:0] ss, estb;
    model_step(1'b1, 1'b0, 20'(BASE+4), 32'h0000_1234, 4'hF, es, ed, estb);
    run_req(1'b1, 1'b0, 20'(BASE+4), 32'h0000_1234, 4'hF, lat, s, d, ss, sc, bad);
    model_step(1'b1, 1'b0, 20'(BASE+4), 32'h0000_AAAA, 4'h2, es, ed, estb);
    run_req(1'b1, 1'b0, 20'(BASE+4), 32'h0000_AAAA, 4'h2, lat, s, d, ss, sc, bad);
    checks++;
    if (ss !== 4'b0010 || sc !== 1 || s !== 2'd0) begin
      failures++; $display("FAIL byte_en_write: stb=%b cycles=%0d sts=%0d required stb=0010 cycles=1 sts=0", ss, sc, s);
    end
    model_step(1'b0, 1'b1, 20'(BASE+4), 32'h0, 4'h0, es, ed, estb);
    run_req(1'b0, 1'b1, 20'(BASE+4), 32'h0, 4'h0, lat, s, d, ss, sc, bad);
    checks++;
    if (d !== 32'h0000_AA34 || d !== ed || s !== 2'd0) begin
      failures++; $display("FAIL byte_en_readback: got %h sts=%0d required 0000aa34 sts=0", d, s);
    end
    // write with no byte enables: OKAY, nothing changes, no strobe
    model_step(1'b1, 1'b0, 20'(BASE+4), 32'hFFFF_FFFF, 4'h0, es, ed, estb);
    run_req(1'b1, 1'b0, 20'(BASE+4), 32'hFFFF_FFFF, 4'h0, lat, s, d, ss, sc, bad);
    checks++;
    if (s !== 2'd0 || sc !== 0 || regs !== m_flat()) begin
      failures++; $display("FAIL byte_en_zero: sts=%0d stb_cycles=%0d regs=%h required sts=0 stb_cycles=0 regs=%h",
                           s, sc, regs, m_flat());
    end
  endtask

  task automatic test_decode_err();
    int lat, sc, bad; logic [1:0] s, es; logic [31:0] d, ed; logic [N-1:0] ss, estb;
    logic [19:0] addrs [5];
    logic wrs [5], rds [5];
    addrs[0] = 20'(BASE + 4*N); wrs[0] = 0; rds[0] = 1;
    addrs[1] = 20'(BASE + 2);   wrs[1] = 0; rds[1] = 1;
    addrs[2] = 20'(BASE - 4);   wrs[2] = 0; rds[2] = 1;
    addrs[3] = 20'(BASE + 4*N); wrs[3] = 1; rds[3] = 0;
    addrs[4] = 20'(BASE + 8);   wrs[4] = 1; rds[4] = 1;
    for (int k = 0; k < 5; k++) begin
      model_step(wrs[k], rds[k], addrs[k], 32'hDEAD_BEEF, 4'hF, es, ed, estb);
      run_req(wrs[k], rds[k], addrs[k], 32'hDEAD_BEEF, 4'hF, lat, s, d, ss, sc, bad);
      checks++;
      if (s !== 2'd1 || d !== 32'd0 || s !== es || sc !== 0 || lat !== LAT || regs !== m_flat()) begin
        failures++; $display("FAIL decode_err[%0d]: addr=%h sts=%0d data=%h stb_cycles=%0d lat=%0d regs=%h required sts=1 data=0 stb_cycles=0 lat=%0d regs=%h",
                             k, addrs[k], s, d, sc, lat, regs, LAT, m_flat());
      end
    end
  endtask

  task automatic test_random();
    int lat, sc, bad, r; logic [1:0] s, es; logic [31:0] d, ed, dat; logic [N-1:0] ss, estb;
    logic wr, rd; logic [19:0] a; logic [3:0] be;
    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      wr = (r < 5) || (r == 9);
      rd = (r >= 5);
      if ($urandom_range(0, 9) < 7) a = 20'(BASE + 4*$urandom_range(0, N-1));
      else                          a = 20'(BASE - 8 + $urandom_range(0, 4*N + 16));
      dat = $urandom();
      be  = 4'($urandom_range(0, 15));
      model_step(wr, rd, a, dat, be, es, ed, estb);
      run_req(wr, rd, a, dat, be, lat, s, d, ss, sc, bad);
      checks++;
      if (lat !== LAT || s !== es || d !== ed || ss !== estb || bad !== 0 || regs !== m_flat()) begin
        failures++; $display("FAIL random[%0d]: wr=%b rd=%b addr=%h be=%h lat=%0d sts=%0d data=%h stb=%b bad=%0d regs=%h required lat=%0d sts=%0d data=%h stb=%b regs=%h",
                             k, wr, rd, a, be, lat, s, d, ss, bad, regs, LAT, es, ed, estb, m_flat());
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat2; logic [1:0] es; logic [31:0] ed, got; logic [N-1:0] estb; bit seen;
    model_step(1'b1, 1'b0, 20'(BASE), 32'h0000_5A5A, 4'h3, es, ed, estb);
    model_step(1'b0, 1'b1, 20'(BASE), 32'h0, 4'h0, es, ed, estb);
    @(negedge clk);
    req_wr = 1; req_rd = 0; req_addr = 20'(BASE); req_data = 32'h0000_5A5A; req_be = 4'h3;
    @(posedge clk); #1; req_wr = 0;
    seen = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      seen = resp_ack;
    end
    // issue the read during the ACK cycle of the write
    req_rd = 1;
    @(posedge clk); #1; req_rd = 0;
    lat2 = -1; got = '0;
    for (int n = 1; n <= 40 && lat2 < 0; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (resp_ack) begin lat2 = n; got = resp_data; end
    end
    checks++;
    if (!seen || lat2 !== LAT || got !== ed) begin
      failures++; $display("FAIL back_to_back: first_ack=%b lat=%0d data=%h required first_ack=1 lat=%0d data=%h",
                           seen, lat2, got, LAT, ed);
    end
    checks++;
    if (dropped !== 1'b0) begin failures++; $display("FAIL back_to_back_dropped: got %b required 0", dropped); end
    @(posedge clk); #1;
  endtask

  task automatic test_dropped();
    int acks, pos; logic [1:0] es; logic [31:0] ed, a_dat; logic [N-1:0] estb;
    a_dat = $urandom();
    model_step(1'b1, 1'b0, 20'(BASE+8), a_dat, 4'hF, es, ed, estb);
    @(negedge clk);
    req_wr = 1; req_addr = 20'(BASE+8); req_data = a_dat; req_be = 4'hF;
    @(posedge clk); #1; req_wr = 0;
    @(posedge clk);
    @(negedge clk);
    req_wr = 1; req_addr = 20'(BASE+12); req_data = ~a_dat; req_be = 4'hF;
    @(posedge clk); #1; req_wr = 0;
    acks = 0; pos = -1;
    for (int k = 0; k < 15; k++) begin
      if (resp_ack) begin acks++; if (pos < 0) pos = k; end
      @(posedge clk); #1;
    end
    checks++;
    if (acks !== 1 || pos !== LAT - 3) begin
      failures++; $display("FAIL dropped_acks: acks=%0d pos=%0d required acks=1 pos=%0d", acks, pos, LAT - 3);
    end
    checks++;
    if (dropped !== 1'b1) begin failures++; $display("FAIL dropped_flag: got %b required 1", dropped); end
    checks++;
    if (regs !== m_flat()) begin failures++; $display("FAIL dropped_regs: got %h required %h", regs, m_flat()); end
  endtask

  task automatic test_reset_in_wait();
    int acks;
    @(negedge clk);
    req_wr = 1; req_addr = 20'(BASE+12); req_data = 32'h0000_5555; req_be = 4'hF;
    @(posedge clk); #1; req_wr = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (regs !== m_flat() || dropped !== 1'b0 || resp_ack !== 1'b0) begin
      failures++; $display("FAIL reset_in_wait_immediate: regs=%h dropped=%b ack=%b required regs=%h dropped=0 ack=0",
                           regs, dropped, resp_ack, m_flat());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (resp_ack) acks++;
    end
    checks++;
    if (acks !== 0 || regs !== m_flat() || dropped !== 1'b0) begin
      failures++; $display("FAIL reset_in_wait_after: acks=%0d regs=%h dropped=%b required acks=0 regs=%h dropped=0",
                           acks, regs, dropped, m_flat());
    end
  endtask

  task automatic test_latency1();
    @(negedge clk);
    b_rd = 1; b_addr = 20'h0;
    @(posedge clk); #1; b_rd = 0;
    checks++;
    if (b_ack !== 1'b1 || b_status !== 2'd0 || b_rdata !== 32'h0000_0078) begin
      failures++; $display("FAIL lat1_read: ack=%b sts=%0d data=%h required ack=1 sts=0 data=00000078", b_ack, b_status, b_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (b_ack !== 1'b0) begin failures++; $display("FAIL lat1_ack_width: ack=%b required 0", b_ack); end
    @(negedge clk);
    b_wr = 1; b_addr = 20'h4; b_data = 32'hFFFF_FFFF; b_be = 4'hF;
    @(posedge clk); #1; b_wr = 0;
    checks++;
    if (b_ack !== 1'b1 || b_stb !== 2'b10) begin
      failures++; $display("FAIL lat1_write: ack=%b stb=%b required ack=1 stb=10", b_ack, b_stb);
    end
    b_rd = 1;
    @(posedge clk); #1; b_rd = 0;
    checks++;
    if (b_ack !== 1'b1 || b_rdata !== 32'h0000_00FF || b_regs !== 16'hFF78 || b_dropped !== 1'b0) begin
      failures++; $display("FAIL lat1_back_to_back: ack=%b data=%h regs=%h dropped=%b required ack=1 data=000000ff regs=ff78 dropped=0",
                           b_ack, b_rdata, b_regs, b_dropped);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_en();
    test_decode_err();
    test_random();
    test_back_to_back();
    test_dropped();
    test_reset_in_wait();
    test_latency1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
